// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and the 32-bit sequencer that drives it:
// ALU opcodes, flag bit positions, wide-operation encodings and sequencer states.
package alu_pkg;

   // 16-bit ALU opcodes
   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_AND   = 8'h01;
   localparam logic [7:0] OP_OR    = 8'h02;
   localparam logic [7:0] OP_XOR   = 8'h03;
   localparam logic [7:0] OP_ADDU  = 8'h06;
   localparam logic [7:0] OP_ADDCU = 8'h08;
   localparam logic [7:0] OP_CMPU  = 8'h0F;
   localparam logic [7:0] OP_LSH   = 8'h84;

   // Flag bit positions inside the 5-bit {Z,C,V,N,L} vector
   localparam int FZ = 4;
   localparam int FC = 3;
   localparam int FV = 2;
   localparam int FN = 1;
   localparam int FL = 0;

   // Wide (32-bit) operation encodings on req_op
   localparam logic [1:0] WOP_ADD  = 2'b00;
   localparam logic [1:0] WOP_CMPU = 2'b01;
   localparam logic [1:0] WOP_LSH  = 2'b10;
   localparam logic [1:0] WOP_XOR  = 2'b11;

   // Sequencer states; every state lasts exactly one cycle
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ADD_LO = 4'd1,
      ST_ADD_HI = 4'd2,
      ST_CMP_HI = 4'd3,
      ST_CMP_LO = 4'd4,
      ST_SH_LO  = 4'd5,
      ST_SH_HI  = 4'd6,
      ST_SH_OR  = 4'd7,
      ST_XOR_LO = 4'd8,
      ST_XOR_HI = 4'd9,
      ST_DONE   = 4'd10
   } seq_state_t;

   // Signed overflow of a 32-bit add from the three sign bits
   function automatic logic add_ovf(input logic a31, input logic b31, input logic c31);
      return (~a31 & ~b31 & c31) | (a31 & b31 & ~c31);
   endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Multi-cycle sequencer that runs 32-bit ADD / unsigned compare / left shift / XOR
// on an external 16-bit combinational ALU. All ALU inputs are registered so the
// path inside a state is: alu_* register -> ALU -> capture register.
module alu_wide_seq
   import alu_pkg::*;
#(
   parameter int SHW = 5
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   output logic [31:0] rsp_c,
   output logic [4:0]  rsp_flags,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [7:0]  alu_opcode,
   output logic        alu_cin,
   input  logic [15:0] alu_c,
   input  logic [4:0]  alu_flags
);

   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

   seq_state_t      r_state;
   logic            r_req_ready;
   logic            r_rsp_valid;
   logic [31:0]     r_rsp_c;
   logic [4:0]      r_rsp_flags;
   logic [15:0]     r_alu_a;
   logic [15:0]     r_alu_b;
   logic [7:0]      r_alu_opcode;
   logic            r_alu_cin;
   logic [31:0]     r_a;
   logic [31:0]     r_b;
   logic [31:0]     r_w;
   logic [15:0]     r_c_lo;
   logic            r_bit;
   logic [SHW-1:0]  r_cnt;

   // Flag bits V/N from the ALU are never consumed, and only bit 15 and the
   // upper half of the shift working word are read back.
   logic            w_unused_bits;
   assign w_unused_bits = ^{alu_flags[FV], alu_flags[FN], r_w[14:0]};

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_c      = r_rsp_c;
   assign rsp_flags  = r_rsp_flags;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_opcode;
   assign alu_cin    = r_alu_cin;

   // Sequencer FSM: accepts a request, steps the ALU through 16-bit slices, publishes the result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_c      <= 32'd0;
         r_rsp_flags  <= 5'd0;
         r_alu_a      <= 16'd0;
         r_alu_b      <= 16'd0;
         r_alu_opcode <= OP_NOP;
         r_alu_cin    <= 1'b0;
         r_a          <= 32'd0;
         r_b          <= 32'd0;
         r_w          <= 32'd0;
         r_c_lo       <= 16'd0;
         r_bit        <= 1'b0;
         r_cnt        <= CNT_ZERO;
      end else begin
         // ALU idles at NOP unless the next state needs it; response is a pulse.
         r_rsp_valid  <= 1'b0;
         r_alu_a      <= 16'd0;
         r_alu_b      <= 16'd0;
         r_alu_opcode <= OP_NOP;
         r_alu_cin    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_a         <= req_a;
                  r_b         <= req_b;
                  r_req_ready <= 1'b0;
                  case (req_op)
                     WOP_ADD: begin
                        r_state      <= ST_ADD_LO;
                        r_alu_a      <= req_a[15:0];
                        r_alu_b      <= req_b[15:0];
                        r_alu_opcode <= OP_ADDU;
                     end
                     WOP_CMPU: begin
                        r_state      <= ST_CMP_HI;
                        r_alu_a      <= req_a[31:16];
                        r_alu_b      <= req_b[31:16];
                        r_alu_opcode <= OP_CMPU;
                     end
                     WOP_LSH: begin
                        r_w   <= req_a;
                        r_cnt <= req_b[SHW-1:0];
                        if (req_b[SHW-1:0] == CNT_ZERO) begin
                           // Zero-length shift returns A untouched.
                           r_state     <= ST_DONE;
                           r_rsp_valid <= 1'b1;
                           r_rsp_c     <= req_a;
                           r_rsp_flags <= {(req_a == 32'd0), 4'b0000};
                        end else begin
                           r_state      <= ST_SH_LO;
                           r_alu_a      <= req_a[15:0];
                           r_alu_opcode <= OP_LSH;
                        end
                     end
                     WOP_XOR: begin
                        r_state      <= ST_XOR_LO;
                        r_alu_a      <= req_a[15:0];
                        r_alu_b      <= req_b[15:0];
                        r_alu_opcode <= OP_XOR;
                     end
                     default: begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                     end
                  endcase
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            ST_ADD_LO: begin
               // Low-half carry feeds straight into the high-half add.
               r_c_lo       <= alu_c;
               r_state      <= ST_ADD_HI;
               r_alu_a      <= r_a[31:16];
               r_alu_b      <= r_b[31:16];
               r_alu_opcode <= OP_ADDCU;
               r_alu_cin    <= alu_flags[FC];
            end
            ST_ADD_HI: begin
               r_state     <= ST_DONE;
               r_rsp_valid <= 1'b1;
               r_rsp_c     <= {alu_c, r_c_lo};
               r_rsp_flags <= {({alu_c, r_c_lo} == 32'd0), alu_flags[FC],
                               add_ovf(r_a[31], r_b[31], alu_c[15]), 1'b0, 1'b0};
            end
            ST_CMP_HI: begin
               if (alu_flags[FZ] == 1'b0) begin
                  // High halves differ: they alone decide the ordering.
                  r_state     <= ST_DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_c     <= 32'd0;
                  r_rsp_flags <= {1'b0, 3'b000, alu_flags[FL]};
               end else begin
                  r_state      <= ST_CMP_LO;
                  r_alu_a      <= r_a[15:0];
                  r_alu_b      <= r_b[15:0];
                  r_alu_opcode <= OP_CMPU;
               end
            end
            ST_CMP_LO: begin
               r_state     <= ST_DONE;
               r_rsp_valid <= 1'b1;
               r_rsp_c     <= 32'd0;
               r_rsp_flags <= {alu_flags[FZ], 3'b000, alu_flags[FL]};
            end
            ST_SH_LO: begin
               // Bit 15 crosses into the high half on this step.
               r_c_lo       <= alu_c;
               r_bit        <= r_w[15];
               r_state      <= ST_SH_HI;
               r_alu_a      <= r_w[31:16];
               r_alu_opcode <= OP_LSH;
            end
            ST_SH_HI: begin
               r_state      <= ST_SH_OR;
               r_alu_a      <= alu_c;
               r_alu_b      <= {15'd0, r_bit};
               r_alu_opcode <= OP_OR;
            end
            ST_SH_OR: begin
               r_w   <= {alu_c, r_c_lo};
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_state     <= ST_DONE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_c     <= {alu_c, r_c_lo};
                  r_rsp_flags <= {({alu_c, r_c_lo} == 32'd0), 4'b0000};
               end else begin
                  r_state      <= ST_SH_LO;
                  r_alu_a      <= r_c_lo;
                  r_alu_opcode <= OP_LSH;
               end
            end
            ST_XOR_LO: begin
               r_c_lo       <= alu_c;
               r_state      <= ST_XOR_HI;
               r_alu_a      <= r_a[31:16];
               r_alu_b      <= r_b[31:16];
               r_alu_opcode <= OP_XOR;
            end
            ST_XOR_HI: begin
               r_state     <= ST_DONE;
               r_rsp_valid <= 1'b1;
               r_rsp_c     <= {alu_c, r_c_lo};
               r_rsp_flags <= {({alu_c, r_c_lo} == 32'd0), 4'b0000};
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed testbench for alu_wide_seq with a behavioural 16-bit ALU whose
// unspecified flag bits are driven X, so any leak shows up in rsp_flags.
module tb_alu_wide_seq;
   import alu_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic [31:0] rsp_c;
   logic [4:0]  rsp_flags;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [7:0]  alu_opcode;
   logic        alu_cin;
   logic [15:0] alu_c;
   logic [4:0]  alu_flags;
   logic [16:0] t_sum;

   int checks = 0;
   int errors = 0;

   alu_wide_seq #(.SHW(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
      .alu_c(alu_c), .alu_flags(alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 16-bit ALU: only the flags each opcode defines are driven.
   always_comb begin
      alu_c     = 16'h0000;
      alu_flags = 5'bxxxxx;
      t_sum     = 17'd0;
      case (alu_opcode)
         OP_ADDU: begin
            t_sum         = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c         = t_sum[15:0];
            alu_flags[FC] = t_sum[16];
         end
         OP_ADDCU: begin
            t_sum         = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            alu_c         = t_sum[15:0];
            alu_flags[FC] = t_sum[16];
         end
         OP_CMPU: begin
            alu_flags[FZ] = (alu_a == alu_b);
            alu_flags[FL] = (alu_a < alu_b);
         end
         OP_LSH: begin
            alu_c         = {alu_a[14:0], 1'b0};
            alu_flags[FC] = alu_a[15];
         end
         OP_OR:  alu_c = alu_a | alu_b;
         OP_XOR: alu_c = alu_a ^ alu_b;
         OP_AND: alu_c = alu_a & alu_b;
         default: alu_c = 16'h0000;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; returns at the first falling edge after accept.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit keep);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid, counting cycles from the accept edge.
   task automatic expect_rsp(input string tag, input int lat, input logic [31:0] c,
                             input logic [4:0] f);
      int k;
      k = 1;
      while (rsp_valid !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, k, lat);
      chk({tag, " rsp_c"}, rsp_c, c);
      chk({tag, " flags"}, {27'd0, rsp_flags}, {27'd0, f});
      chk({tag, " done_nop"}, {24'd0, alu_opcode}, {24'd0, OP_NOP});
   endtask

   // Cycle after the response: idle again, pulse gone, result held.
   task automatic after_rsp(input string tag, input logic [31:0] c);
      @(negedge clk);
      chk({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
      chk({tag, " valid_pulse"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, " held"}, rsp_c, c);
   endtask

   initial begin
      bit saw_valid;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 32'd0;
      req_b     = 32'd0;
      repeat (3) @(negedge clk);

      chk("rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst rsp_c", rsp_c, 32'd0);
      chk("rst flags", {27'd0, rsp_flags}, 32'd0);
      chk("rst alu_ab", {alu_a, alu_b}, 32'd0);
      chk("rst alu_op_cin", {23'd0, alu_opcode, alu_cin}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      issue(WOP_ADD, 32'h0000FFFF, 32'h00000001, 1'b0);
      expect_rsp("add_carrylo", 3, 32'h00010000, 5'b00000);
      after_rsp("add_carrylo", 32'h00010000);

      issue(WOP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      expect_rsp("add_wrap", 3, 32'h00000000, 5'b11000);
      after_rsp("add_wrap", 32'h00000000);

      issue(WOP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0);
      expect_rsp("add_ovf", 3, 32'h80000000, 5'b00100);
      after_rsp("add_ovf", 32'h80000000);

      issue(WOP_CMPU, 32'h00010000, 32'h0000FFFF, 1'b0);
      expect_rsp("cmp_hi_gt", 2, 32'h00000000, 5'b00000);
      after_rsp("cmp_hi_gt", 32'h00000000);

      issue(WOP_CMPU, 32'h12340005, 32'h12340007, 1'b0);
      expect_rsp("cmp_lo_lt", 3, 32'h00000000, 5'b00001);
      after_rsp("cmp_lo_lt", 32'h00000000);

      issue(WOP_CMPU, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      expect_rsp("cmp_eq", 3, 32'h00000000, 5'b10000);
      after_rsp("cmp_eq", 32'h00000000);

      issue(WOP_LSH, 32'h00008001, 32'h00000001, 1'b0);
      expect_rsp("lsh1", 4, 32'h00010002, 5'b00000);
      after_rsp("lsh1", 32'h00010002);

      issue(WOP_LSH, 32'h00000001, 32'h0000001F, 1'b0);
      expect_rsp("lsh31", 94, 32'h80000000, 5'b00000);
      after_rsp("lsh31", 32'h80000000);

      issue(WOP_LSH, 32'h12345678, 32'hFFFFFFE0, 1'b0);
      expect_rsp("lsh0", 1, 32'h12345678, 5'b00000);
      after_rsp("lsh0", 32'h12345678);

      issue(WOP_LSH, 32'h80000000, 32'h00000001, 1'b0);
      expect_rsp("lsh_out", 4, 32'h00000000, 5'b10000);
      after_rsp("lsh_out", 32'h00000000);

      // Back-to-back: req_valid stays high, second request presented during DONE.
      issue(WOP_XOR, 32'hA5A5FFFF, 32'hA5A5FFFF, 1'b1);
      expect_rsp("xor_zero", 3, 32'h00000000, 5'b10000);
      req_a = 32'h12345678;
      req_b = 32'h0F0F0F0F;
      @(negedge clk);
      chk("b2b ready", {31'd0, req_ready}, 32'd1);
      chk("b2b no_pulse", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("b2b accepted", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      expect_rsp("xor_b2b", 3, 32'h1D3B5977, 5'b00000);
      after_rsp("xor_b2b", 32'h1D3B5977);

      // Reset while the shifter is in SH_HI.
      issue(WOP_LSH, 32'h00000003, 32'h00000005, 1'b0);
      chk("shlo alu_a", {16'd0, alu_a}, 32'h00000003);
      @(negedge clk);
      chk("shhi opcode", {24'd0, alu_opcode}, {24'd0, OP_LSH});
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort ready", {31'd0, req_ready}, 32'd1);
      chk("abort valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort rsp_c", rsp_c, 32'd0);
      chk("abort flags", {27'd0, rsp_flags}, 32'd0);
      chk("abort alu_ab", {alu_a, alu_b}, 32'd0);
      chk("abort alu_op_cin", {23'd0, alu_opcode, alu_cin}, 32'd0);
      reset_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) saw_valid = 1'b1;
      end
      chk("abort no_rsp", {31'd0, saw_valid}, 32'd0);

      issue(WOP_ADD, 32'h0001FFFF, 32'h00020001, 1'b0);
      expect_rsp("add_after_rst", 3, 32'h00040000, 5'b00000);
      after_rsp("add_after_rst", 32'h00040000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
